// File: rtl/uart_word_packer.sv
// uart_word_packer
//   Packs the uart_rx byte stream into BYTES_PER_WORD-byte words for the
//   pixel/config path. Byte order is selectable. An optional sync-byte framing
//   mode is available. An inter-byte timeout discards a partial word.
//   Everything runs in the single sys_clk (50 MHz) domain.
//
// Ports
//   sys_clk      in   1     clock
//   sys_rst_n    in   1     asynchronous, active-low reset
//   in_data      in   8     received byte
//   in_flag      in   1     1-cycle strobe: in_data is valid
//   out_data     out  8*N   assembled word, stable while out_valid=1
//   out_valid    out  1     word available
//   out_ready    in   1     consumer takes the word
//   overflow     out  1     sticky: a completed word was dropped
//   clr_err      in   1     clears overflow (a new drop in the same cycle wins)
//   timeout_evt  out  1     1-cycle pulse: a partial word was discarded
//   busy         out  1     partial word in progress, or framed word open
//   state_dbg    out  1     FSM state (0 = HUNT, 1 = COLLECT)
//
// Handshake: a word transfers on any rising edge where out_valid & out_ready.
// out_valid stays high until that transfer happens. out_data does not change
// while out_valid is high, except when a new word completes on the same edge
// as the transfer. out_ready has no effect while out_valid is low.
module uart_word_packer #(
    parameter int         BYTES_PER_WORD = 3,
    parameter int         MSB_FIRST      = 1,
    parameter int         SYNC_EN        = 0,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYC    = 50_000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_flag,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    input  logic                        clr_err,
    output logic                        timeout_evt,
    output logic                        busy,
    output logic                        state_dbg
);

    localparam int W     = 8 * BYTES_PER_WORD;
    localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam state_t RST_STATE = (SYNC_EN != 0) ? HUNT : COLLECT;

    state_t           state, state_nxt;
    logic [W-1:0]     sr;
    logic [W-1:0]     sr_shift;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic             byte_acc;
    logic             word_done;
    logic             tmo_hit;
    logic             drop;

    // Shifting the whole register keeps the same expression valid for N=1.
    // In that case the old contents shift out completely.
    always_comb begin
        if (MSB_FIRST != 0) begin
            sr_shift = (sr << 8) | W'(in_data);
        end else begin
            sr_shift = (sr >> 8) | (W'(in_data) << (W - 8));
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        byte_acc  = 1'b0;
        word_done = 1'b0;
        // A byte arriving on the expiry cycle takes priority, so in_flag masks the timeout.
        tmo_hit   = (TIMEOUT_CYC > 0) && (cnt != '0) && !in_flag && (timer == TMR_LAST);
        case (state)
            HUNT: begin
                if (in_flag && (in_data == SYNC_BYTE)) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (in_flag) begin
                    byte_acc = 1'b1;
                    if (cnt == CNT_LAST) begin
                        word_done = 1'b1;
                        if (SYNC_EN != 0) state_nxt = HUNT;
                    end
                end else if (tmo_hit && (SYNC_EN != 0)) begin
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    assign drop = word_done && out_valid && !out_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr          <= '0;
            cnt         <= '0;
            timer       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= tmo_hit;

            if (byte_acc) begin
                sr  <= sr_shift;
                cnt <= word_done ? '0 : cnt + 1'b1;
            end else if (tmo_hit) begin
                sr  <= '0;
                cnt <= '0;
            end

            // The timer measures the idle time since the last byte of a partial word.
            if (in_flag || (cnt == '0) || tmo_hit) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (word_done && !drop) begin
                out_data  <= sr_shift;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy      = (cnt != '0) || ((SYNC_EN != 0) && (state == COLLECT));
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer. Three instances share one stimulus stream:
//   a: MSB first, timeout 100 cycles
//   b: LSB first, no timeout
//   c: sync framing, MSB first, no timeout
// Each instance has its own expected-word queue. A monitor on the falling
// edge pops one entry for every word that is accepted.
module tb_uart_word_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_flag;
  logic        out_ready;
  logic        clr_err;

  logic [23:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_ovf, b_ovf, c_ovf;
  logic        a_tmo, b_tmo, c_tmo;
  logic        a_busy, b_busy, c_busy;
  logic        a_st, b_st, c_st;

  int n_assert = 0;
  int n_fail   = 0;

  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  logic [23:0] exp_c[$];

  uart_word_packer #(.BYTES_PER_WORD(3), .MSB_FIRST(1), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(100)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data), .in_flag(in_flag),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .overflow(a_ovf),
    .clr_err(clr_err), .timeout_evt(a_tmo), .busy(a_busy), .state_dbg(a_st));

  uart_word_packer #(.BYTES_PER_WORD(3), .MSB_FIRST(0), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(0)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data), .in_flag(in_flag),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .overflow(b_ovf),
    .clr_err(clr_err), .timeout_evt(b_tmo), .busy(b_busy), .state_dbg(b_st));

  uart_word_packer #(.BYTES_PER_WORD(3), .MSB_FIRST(1), .SYNC_EN(1), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(0)) dut_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data), .in_flag(in_flag),
    .out_data(c_data), .out_valid(c_valid), .out_ready(out_ready), .overflow(c_ovf),
    .clr_err(clr_err), .timeout_evt(c_tmo), .busy(c_busy), .state_dbg(c_st));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [23:0] got, inout logic [23:0] q[$]);
    logic [23:0] e;
    n_assert++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed unexpected word %h expected none", tag, got);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      check(tag, {8'h0, got}, {8'h0, e});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_ready && a_valid) pop_check("a_word", a_data, exp_a);
    if (rst_n && out_ready && b_valid) pop_check("b_word", b_data, exp_b);
    if (rst_n && out_ready && c_valid) pop_check("c_word", c_data, exp_c);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b;
    in_flag = 1'b1;
    @(posedge clk);
    #1;
    in_flag = 1'b0;
    in_data = 8'h00;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    in_flag = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", {8'h0, a_data | b_data | c_data}, 32'h0);
    check("rst_out_valid", {31'h0, a_valid | b_valid | c_valid}, 32'h0);
    check("rst_overflow", {31'h0, a_ovf | b_ovf | c_ovf}, 32'h0);
    check("rst_timeout_evt", {31'h0, a_tmo | b_tmo | c_tmo}, 32'h0);
    check("rst_busy", {31'h0, a_busy | b_busy | c_busy}, 32'h0);
    check("rst_state", {29'h0, a_st, b_st, c_st}, 32'h6);
    rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------- directed sequence ----------------
  int tmo_early;
  int tmo_late;
  int tmo_b;

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_flag   = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    do_reset();

    // Basic packing in both byte orders, with 1-cycle latency.
    exp_a.push_back(24'h123456);
    exp_b.push_back(24'h563412);
    send(8'h12);
    send(8'h34);
    check("valid_before_last", {31'h0, a_valid}, 32'h0);
    check("busy_mid_word", {31'h0, a_busy}, 32'h1);
    send(8'h56);
    check("latency_valid", {31'h0, a_valid}, 32'h1);
    check("msb_first_data", {8'h0, a_data}, 32'h123456);
    check("lsb_first_data", {8'h0, b_data}, 32'h563412);
    check("hunt_no_word", {31'h0, c_valid}, 32'h0);
    tick(2);
    check("valid_after_accept", {31'h0, a_valid}, 32'h0);

    // Backpressure: the second word is dropped and the first is held.
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i));
    check("ovf_hold_data_a", {8'h0, a_data}, 32'h010203);
    check("ovf_hold_data_b", {8'h0, b_data}, 32'h030201);
    check("ovf_set_a", {31'h0, a_ovf}, 32'h1);
    check("ovf_set_b", {31'h0, b_ovf}, 32'h1);
    check("ovf_clear_c", {31'h0, c_ovf}, 32'h0);
    tick(3);
    check("ovf_sticky", {31'h0, a_ovf}, 32'h1);
    check("valid_held", {31'h0, a_valid}, 32'h1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovf_cleared", {31'h0, a_ovf}, 32'h0);
    exp_a.push_back(24'h010203);
    exp_b.push_back(24'h030201);
    out_ready = 1'b1;
    tick(2);
    check("valid_drop_after_ready", {31'h0, a_valid}, 32'h0);

    // Inter-byte timeout on dut_a only.
    do_reset();
    exp_a.push_back(24'hAABBCC);
    exp_b.push_back(24'hAA2211);
    send(8'h11);
    send(8'h22);
    tmo_early = 0;
    tmo_late  = 0;
    tmo_b     = 0;
    repeat (99) begin
      @(negedge clk);
      if (a_tmo) tmo_early++;
    end
    repeat (6) begin
      @(negedge clk);
      if (a_tmo) tmo_late++;
      if (b_tmo) tmo_b++;
    end
    check("tmo_not_early", tmo_early, 0);
    check("tmo_pulse_once", tmo_late, 1);
    check("tmo_disabled_b", tmo_b, 0);
    check("tmo_busy_clear", {31'h0, a_busy}, 32'h0);
    check("tmo_valid_untouched", {31'h0, a_valid}, 32'h0);
    tick(1);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    check("after_tmo_data", {8'h0, a_data}, 32'hAABBCC);
    tick(2);

    // Sync framing: only dut_c waits for A5; the others treat A5 as data.
    do_reset();
    exp_c.push_back(24'h010203);
    exp_a.push_back(24'h11A501);
    exp_a.push_back(24'h020304);
    exp_b.push_back(24'h01A511);
    exp_b.push_back(24'h040302);
    send(8'h11);
    check("sync_ignore_busy", {31'h0, c_busy}, 32'h0);
    send(8'hA5);
    check("sync_open_busy", {31'h0, c_busy}, 32'h1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    check("sync_word_data", {8'h0, c_data}, 32'h010203);
    send(8'h04);
    send(8'h05);
    send(8'h06);
    tick(1);
    check("sync_no_unframed", {31'h0, c_valid}, 32'h0);
    check("sync_back_to_hunt", {31'h0, c_st}, 32'h0);
    tick(2);

    // Reset in the middle of a word discards the partial bytes.
    do_reset();
    send(8'h77);
    send(8'h88);
    do_reset();
    check("rst_mid_busy", {31'h0, a_busy}, 32'h0);
    exp_a.push_back(24'h010203);
    exp_b.push_back(24'h030201);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    check("post_rst_data", {8'h0, a_data}, 32'h010203);
    tick(3);

    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    check("c_queue_empty", exp_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
